// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronise/deglitch pins, check start/parity/stop, abort on timeout.
// Optional saturating error counter on port err_count when PS2_ERR_COUNT_EN is defined.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
`ifdef PS2_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic          clk_sync_p0, clk_sync_p1;
  logic          data_sync_p0, data_sync_p1;
  logic          clk_filt, clk_filt_p2;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] tcnt;
  logic          timeout, shift_en, par_en, valid_set, err_set;

  // stage p0/p1: two-flop synchronisers; idle-high so reset cannot fake an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk;
      clk_sync_p1  <= clk_sync_p0;
    end
    data_sync_p0 <= ps2_data;
    data_sync_p1 <= data_sync_p0;
  end

  // stage p2: filtered clock moves only after FILTER_LEN equal samples of the new level
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt    <= 1'b1;
      clk_filt_p2 <= 1'b1;
      filt_cnt    <= '0;
    end else begin
      clk_filt_p2 <= clk_filt;
      if (clk_sync_p1 != clk_filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync_p1;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall    = clk_filt_p2 & ~clk_filt;
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    valid_set  = 1'b0;
    err_set    = 1'b0;
    if (fall) begin
      case (state)
        IDLE:   if (!data_sync_p1) state_next = DATA;
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_en     = 1'b1;
          state_next = STOP;
        end
        default: begin
          if (data_sync_p1 && (^{shift_reg, parity_bit})) valid_set = 1'b1;
          else                                             err_set   = 1'b1;
          state_next = IDLE;
        end
      endcase
    end else if (timeout) begin
      // an edge in the same cycle takes the branch above, so it always wins
      state_next = IDLE;
      err_set    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_reg  <= {data_sync_p1, shift_reg[7:1]};
    if (par_en)   parity_bit <= data_sync_p1;
    if (reset) begin
      bit_cnt     <= '0;
      tcnt        <= '0;
      scan_code   <= 8'h00;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;
      scan_valid  <= valid_set;
      frame_error <= err_set;
      if (valid_set) scan_code <= shift_reg;
    end
  end

`ifdef PS2_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)        err_count <= 8'h00;
    else if (err_set) err_count <= sat_inc8(err_count);
  end
`endif

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: clean, back-to-back, bad parity/stop, timeout, glitch frames.
// Builds with or without PS2_ERR_COUNT_EN.
module tb_ps2_frame_receiver;

  localparam int F    = 4;
  localparam int T    = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;
`ifdef PS2_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  ps2_frame_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .frame_error (frame_error)
`ifdef PS2_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         valid_cyc = 0;
  int         err_cyc = 0;
  int         last_fall = 0;
  logic       overlap = 1'b0;
  logic [7:0] codes [0:15];
  int         checks = 0;
  int         passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_valid) begin
      if (n_valid < 16) codes[n_valid] = scan_code;
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_error) begin
      n_err   = n_err + 1;
      err_cyc = cyc;
    end
    if (scan_valid && frame_error) overlap = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (half) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] code, input logic par_flip, input logic stop);
    return {stop, (~^code) ^ par_flip, code, 1'b0};
  endfunction

  task automatic settle();
    repeat (F + 12) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("reset_scan_code", scan_code, 8'h00);
    check("reset_scan_valid", scan_valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
`ifdef PS2_ERR_COUNT_EN
    check("reset_err_count", err_count, 8'h00);
`endif
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // clean 0x1C; valid seen 2 sync + F filter + 1 edge-detect cycles after the raw fall
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, HALF);
    settle();
    check("t1_valid_count", n_valid, 1);
    check("t1_code", codes[0], 8'h1C);
    check("t1_scan_code", scan_code, 8'h1C);
    check("t1_no_error", n_err, 0);
    check("t1_latency", valid_cyc - last_fall, F + 3);

    send_bits(frame(8'hF0, 1'b0, 1'b1), 11, HALF);
    send_bits(frame(8'h12, 1'b0, 1'b1), 11, HALF);
    settle();
    check("t2_valid_count", n_valid, 3);
    check("t2_code_f0", codes[1], 8'hF0);
    check("t2_code_12", codes[2], 8'h12);
    check("t2_no_error", n_err, 0);

    send_bits(frame(8'h1C, 1'b1, 1'b1), 11, HALF);
    settle();
    check("t3_err_count", n_err, 1);
    check("t3_no_valid", n_valid, 3);
    check("t3_code_held", scan_code, 8'h12);
    check("t3_err_latency", err_cyc - last_fall, F + 3);
`ifdef PS2_ERR_COUNT_EN
    check("t3_err_counter", err_count, 8'h01);
`endif

    send_bits(frame(8'h5A, 1'b0, 1'b0), 11, HALF);
    settle();
    check("t4_err_count", n_err, 2);
    check("t4_no_valid", n_valid, 3);

    send_bits(frame(8'h29, 1'b0, 1'b1), 5, HALF);
    repeat (T + 40) @(negedge clk);
    check("t5_timeout_err", n_err, 3);
    check("t5_timeout_latency", err_cyc - last_fall, F + T + 3);
    check("t5_no_valid", n_valid, 3);
    send_bits(frame(8'h29, 1'b0, 1'b1), 11, HALF);
    settle();
    check("t5_valid_count", n_valid, 4);
    check("t5_code", scan_code, 8'h29);

    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (F - 2) @(negedge clk);
    ps2_clk = 1'b1;
    settle();
    send_bits(11'h7FF, 1, HALF);
    settle();
    check("t6_no_valid", n_valid, 4);
    check("t6_no_error", n_err, 3);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, HALF);
    settle();
    check("t6_resync_valid", n_valid, 5);
    check("t6_resync_code", scan_code, 8'h1C);
    check("no_overlap", overlap, 1'b0);

`ifdef PS2_ERR_COUNT_EN
    check("t6_err_counter", err_count, 8'h03);
    for (int k = 0; k < 300; k++) send_bits(frame(8'h00, 1'b0, 1'b0), 11, 8);
    settle();
    check("t6_forced_errs", n_err, 303);
    check("t6_err_saturated", err_count, 8'hFF);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
